// File: rtl/edic_debug_pkg.sv
// Shared types and constants for the EDiC debug step/run controller.
package edic_debug_pkg;

  localparam int DBG_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    HALT       = 2'd0,
    STEP_INSTR = 2'd1,
    RUN        = 2'd2,
    BREAK      = 2'd3
  } dbg_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Step button conditioning: 2-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted rising edge.
module button_debouncer
  import edic_debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step_req
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DBG_SYNC_STAGES-1:0] sync_reg;
  logic                       level_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic                       synced;

  assign synced = sync_reg[DBG_SYNC_STAGES-1];

  // The counter only runs while the synced level differs from the accepted
  // one, so any bounce back to the accepted level reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      step_req  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[DBG_SYNC_STAGES-2:0], btn};
      step_req <= 1'b0;
      if (synced == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= synced;
        cnt_reg   <= '0;
        step_req  <= synced;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_step_ctrl.sv
// CPU step/run controller: microcycle/instruction step, free run and, when
// DEBUG_BREAKPOINT_EN is defined, run-mode breakpoints on the next PC.
module debug_step_ctrl
  import edic_debug_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_BP          = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                                      i_oszClk,
  input  logic                                      i_nReset,
  input  logic                                      i_btnStep,
  input  logic                                      i_swInstrNCycle,
  input  logic                                      i_swStepNRun,
  input  logic                                      i_swEnableBreakpoint,
  input  logic [NUM_BP*ADDR_WIDTH-1:0]              i_bpAddress,
  input  logic [NUM_BP-1:0]                         i_bpValid,
  input  logic [ADDR_WIDTH-1:0]                     i_pc,
  input  logic                                      i_instrBoundary,
  output logic                                      o_cpuClkEn,
  output logic                                      o_halted,
  output logic                                      o_bpHit,
  output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] o_bpHitIdx
);

  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  dbg_state_t                 state_reg;
  logic                       step_req;
  logic [DBG_SYNC_STAGES-1:0] instr_sync_reg;
  logic [DBG_SYNC_STAGES-1:0] step_sync_reg;
  logic                       sw_instr;
  logic                       sw_step;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (i_oszClk),
    .rst_n    (i_nReset),
    .btn      (i_btnStep),
    .step_req (step_req)
  );

  // Step/run synchroniser resets to "step" so a fresh reset never starts running.
  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      instr_sync_reg <= '0;
      step_sync_reg  <= '1;
    end else begin
      instr_sync_reg <= {instr_sync_reg[DBG_SYNC_STAGES-2:0], i_swInstrNCycle};
      step_sync_reg  <= {step_sync_reg[DBG_SYNC_STAGES-2:0], i_swStepNRun};
    end
  end

  assign sw_instr = instr_sync_reg[DBG_SYNC_STAGES-1];
  assign sw_step  = step_sync_reg[DBG_SYNC_STAGES-1];

`ifdef DEBUG_BREAKPOINT_EN
  logic [DBG_SYNC_STAGES-1:0] bpen_sync_reg;
  logic [NUM_BP-1:0]          hit_vec;
  logic [IDX_W-1:0]           bp_idx;
  logic                       bp_match;

  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      bpen_sync_reg <= '0;
    end else begin
      bpen_sync_reg <= {bpen_sync_reg[DBG_SYNC_STAGES-2:0], i_swEnableBreakpoint};
    end
  end

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_cmp
    assign hit_vec[gi] = i_bpValid[gi] && (i_pc == i_bpAddress[gi*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  // Scan from the top so the lowest matching entry wins.
  always_comb begin
    bp_idx = '0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (hit_vec[k]) bp_idx = IDX_W'(k);
    end
  end

  assign bp_match = bpen_sync_reg[DBG_SYNC_STAGES-1] && (|hit_vec);
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{i_bpAddress, i_bpValid, i_swEnableBreakpoint, i_pc};
`endif

  always_ff @(posedge i_oszClk or negedge i_nReset) begin
    if (!i_nReset) begin
      state_reg  <= HALT;
      o_cpuClkEn <= 1'b0;
      o_halted   <= 1'b1;
      o_bpHit    <= 1'b0;
      o_bpHitIdx <= '0;
    end else begin
      case (state_reg)
        HALT: begin
          o_cpuClkEn <= 1'b0;
          if (!sw_step) begin
            state_reg  <= RUN;
            o_cpuClkEn <= 1'b1;
            o_halted   <= 1'b0;
          end else if (step_req) begin
            o_cpuClkEn <= 1'b1;
            if (sw_instr) begin
              state_reg <= STEP_INSTR;
              o_halted  <= 1'b0;
            end
          end
        end
        STEP_INSTR: begin
          if (o_cpuClkEn && i_instrBoundary) begin
            state_reg  <= HALT;
            o_cpuClkEn <= 1'b0;
            o_halted   <= 1'b1;
          end
        end
        RUN: begin
`ifdef DEBUG_BREAKPOINT_EN
          // The matching boundary cycle has already executed; stop right after it.
          if (o_cpuClkEn && i_instrBoundary && bp_match) begin
            state_reg  <= BREAK;
            o_cpuClkEn <= 1'b0;
            o_halted   <= 1'b1;
            o_bpHit    <= 1'b1;
            o_bpHitIdx <= bp_idx;
          end else
`endif
          if (sw_step) begin
            state_reg <= STEP_INSTR;
          end
        end
`ifdef DEBUG_BREAKPOINT_EN
        BREAK: begin
          if (step_req) begin
            o_bpHit <= 1'b0;
            if (!sw_step) begin
              state_reg  <= RUN;
              o_cpuClkEn <= 1'b1;
              o_halted   <= 1'b0;
            end else if (sw_instr) begin
              state_reg  <= STEP_INSTR;
              o_cpuClkEn <= 1'b1;
              o_halted   <= 1'b0;
            end else begin
              state_reg  <= HALT;
              o_cpuClkEn <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_reg  <= HALT;
          o_cpuClkEn <= 1'b0;
          o_halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed bench for debug_step_ctrl with DEBOUNCE_CYCLES=4; breakpoint
// expectations follow DEBUG_BREAKPOINT_EN.
module tb_debug_step_ctrl;

  logic        clk;
  logic        n_reset;
  logic        btn;
  logic        sw_instr;
  logic        sw_step;
  logic        sw_bpen;
  logic [63:0] bp_addr;
  logic [3:0]  bp_valid;
  logic [15:0] pc_m;
  logic        boundary;
  logic        en;
  logic        halted;
  logic        bp_hit;
  logic [1:0]  bp_idx;

  logic [1:0]  ustep;
  logic        model_clr;

  int checks = 0;
  int errors = 0;

  debug_step_ctrl #(
    .ADDR_WIDTH      (16),
    .NUM_BP          (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_oszClk             (clk),
    .i_nReset             (n_reset),
    .i_btnStep            (btn),
    .i_swInstrNCycle      (sw_instr),
    .i_swStepNRun         (sw_step),
    .i_swEnableBreakpoint (sw_bpen),
    .i_bpAddress          (bp_addr),
    .i_bpValid            (bp_valid),
    .i_pc                 (pc_m),
    .i_instrBoundary      (boundary),
    .o_cpuClkEn           (en),
    .o_halted             (halted),
    .o_bpHit              (bp_hit),
    .o_bpHitIdx           (bp_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: three microcycles per instruction, PC advances on each completed boundary.
  assign boundary = (ustep == 2'd2);
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ustep <= 2'd0;
      pc_m  <= 16'h0020;
    end else if (model_clr) begin
      ustep <= 2'd0;
      pc_m  <= 16'h0020;
    end else if (en) begin
      if (ustep == 2'd2) begin
        ustep <= 2'd0;
        pc_m  <= pc_m + 16'd1;
      end else begin
        ustep <= ustep + 2'd1;
      end
    end
  end

  task automatic clear_model();
    @(negedge clk);
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      btn = ~btn; sw_instr = ~sw_instr; sw_step = ~sw_step; sw_bpen = ~sw_bpen;
      bp_valid = ~bp_valid;
      #1;
      checks++;
      if (en !== 1'b0 || halted !== 1'b1 || bp_hit !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: en=%b halted=%b bp_hit=%b expected 0/1/0", k, en, halted, bp_hit);
      end
    end
    btn = 1'b0; sw_instr = 1'b0; sw_step = 1'b1; sw_bpen = 1'b0; bp_valid = 4'b0000;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (en !== 1'b0 || halted !== 1'b1 || bp_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: en=%b halted=%b idx=%0d expected 0/1/0", en, halted, bp_idx);
    end
    $display("test_reset done");
  endtask

  task automatic test_cycle_step();
    int pulses;
    pulses = 0;
    clear_model();
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (en) pulses++;
      checks++;
      if (en !== (k == 7) || halted !== 1'b1) begin
        errors++;
        $display("FAIL cycle_step edge %0d: en=%b halted=%b expected en=%b halted=1", k, en, halted, (k == 7));
      end
      if (k == 10) btn = 1'b0;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL cycle_step_count: got %0d pulses expected 1", pulses);
    end
    $display("test_cycle_step pulses=%0d", pulses);
  endtask

  task automatic press_and_expect_instr(input string name);
    int cnt;
    logic exp_en;
    cnt = 0;
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_en = (k >= 7 && k <= 9);
      if (en) cnt++;
      checks++;
      if (en !== exp_en || halted !== !exp_en) begin
        errors++;
        $display("FAIL %s edge %0d: en=%b halted=%b expected en=%b halted=%b", name, k, en, halted, exp_en, !exp_en);
      end
      if (k == 10) btn = 1'b0;
    end
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("FAIL %s_count: got %0d enable cycles expected 3", name, cnt);
    end
    $display("%s enable_cycles=%0d", name, cnt);
  endtask

  task automatic test_instr_step();
    sw_instr = 1'b1;
    repeat (5) @(negedge clk);
    clear_model();
    press_and_expect_instr("instr_step");
  endtask

  task automatic test_bounce();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (en !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge %0d: en=%b expected 0", k, en);
      end
      btn = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
    end
    $display("test_bounce done");
  endtask

  task automatic test_run_break();
    bit found;
    found = 1'b0;
    bp_addr = '0;
    bp_addr[0*16 +: 16] = 16'h0028;
    bp_addr[2*16 +: 16] = 16'h0028;
    bp_addr[3*16 +: 16] = 16'h0028;
    bp_valid = 4'b1100;
    sw_bpen = 1'b1;
    sw_instr = 1'b0;
    repeat (3) @(negedge clk);
    clear_model();
    sw_step = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL run_latency_early: en=%b expected 0", en);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL run_latency: en=%b halted=%b expected 1/0", en, halted);
    end
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (en && boundary && pc_m == 16'h0028) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run_reach_bp: pc=%0h never reached 0028 on an enabled boundary", pc_m);
    end
    @(negedge clk);
    checks++;
`ifdef DEBUG_BREAKPOINT_EN
    if (en !== 1'b0 || halted !== 1'b1 || bp_hit !== 1'b1 || bp_idx !== 2'd2) begin
      errors++;
      $display("FAIL bp_hit: en=%b halted=%b hit=%b idx=%0d expected 0/1/1/2", en, halted, bp_hit, bp_idx);
    end
`else
    if (en !== 1'b1 || halted !== 1'b0 || bp_hit !== 1'b0 || bp_idx !== 2'd0) begin
      errors++;
      $display("FAIL bp_ignored: en=%b halted=%b hit=%b idx=%0d expected 1/0/0/0", en, halted, bp_hit, bp_idx);
    end
`endif
    sw_bpen = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
`ifdef DEBUG_BREAKPOINT_EN
    if (en !== 1'b0 || bp_hit !== 1'b1 || pc_m !== 16'h0029) begin
      errors++;
      $display("FAIL break_sticky: en=%b hit=%b pc=%0h expected 0/1/0029", en, bp_hit, pc_m);
    end
`else
    if (en !== 1'b1 || bp_hit !== 1'b0) begin
      errors++;
      $display("FAIL run_continues: en=%b hit=%b expected 1/0", en, bp_hit);
    end
`endif
    sw_bpen = 1'b1;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (en !== 1'b1 || halted !== 1'b0 || bp_hit !== 1'b0) begin
      errors++;
      $display("FAIL resume_run: en=%b halted=%b hit=%b expected 1/0/0", en, halted, bp_hit);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (pc_m <= 16'h0029) begin
      errors++;
      $display("FAIL resume_pc: pc=%0h expected above 0029", pc_m);
    end
    sw_step = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (halted) found = 1'b1;
    end
    checks++;
    if (!found || en !== 1'b0) begin
      errors++;
      $display("FAIL run_to_halt: halted=%b en=%b expected 1/0 within 20 cycles", halted, en);
    end
    $display("test_run_break pc=%0h hit=%b idx=%0d", pc_m, bp_hit, bp_idx);
  endtask

  task automatic test_reset_mid_step();
    bit seen;
    seen = 1'b0;
    sw_instr = 1'b1;
    repeat (10) @(negedge clk);
    clear_model();
    btn = 1'b1;
    for (int k = 0; k < 15 && !seen; k++) begin
      @(negedge clk);
      if (en) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_step_start: en never rose within 15 cycles");
    end
    #2;
    n_reset = 1'b0;
    btn = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || halted !== 1'b1 || bp_hit !== 1'b0 || bp_idx !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b halted=%b hit=%b idx=%0d expected 0/1/0/0", en, halted, bp_hit, bp_idx);
    end
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (en !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: en=%b halted=%b expected 0/1", k, en, halted);
      end
    end
    press_and_expect_instr("post_reset_step");
  endtask

  initial begin
    n_reset   = 1'b0;
    btn       = 1'b0;
    sw_instr  = 1'b0;
    sw_step   = 1'b1;
    sw_bpen   = 1'b0;
    bp_addr   = '0;
    bp_valid  = 4'b0000;
    model_clr = 1'b0;
    test_reset();
    test_cycle_step();
    test_instr_step();
    test_bounce();
    test_run_break();
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_step_ctrl.md
# debug_step_ctrl

Parametrised CPU step/run controller for the EDiC datapath. It takes the raw step button and the mode switches, debounces and synchronises them, and generates the single-cycle CPU clock enable. It supports microcycle step, whole-instruction step, free run, and up to `NUM_BP` run-mode breakpoints matched on the next-instruction address. It sits between the board controls and the datapath's clock-enable input, clocked from the oscillator domain.

## Interface
- `ADDR_WIDTH`, 16, width of PC and breakpoint addresses
- `NUM_BP`, 4, number of breakpoint comparators (1..16)
- `DEBOUNCE_CYCLES`, 50000, number of cycles a synced button level must be stable before it is accepted (10 ms at 5 MHz)

- `i_oszClk`  in  1  system clock, single clock domain
- `i_nReset`  in  1  reset, asynchronous assert, active-low
- `i_btnStep`  in  1  raw step button, asynchronous, bouncing; 1 = pressed
- `i_swInstrNCycle`  in  1  1 = instruction step, 0 = microcycle step; asynchronous
- `i_swStepNRun`  in  1  1 = step mode, 0 = run; asynchronous
- `i_swEnableBreakpoint`  in  1  global breakpoint enable; asynchronous
- `i_bpAddress`  in  NUM_BP*ADDR_WIDTH  breakpoint addresses; entry k is at bits [k*ADDR_WIDTH +: ADDR_WIDTH]; quasi-static
- `i_bpValid`  in  NUM_BP  per-entry enable
- `i_pc`  in  ADDR_WIDTH  address of the next instruction; valid only while `i_instrBoundary`=1
- `i_instrBoundary`  in  1  high in the last microcycle of an instruction
- `o_cpuClkEn`  out  1  registered; the CPU advances one microcycle per high cycle
- `o_halted`  out  1  registered; 1 in HALT and BREAK
- `o_bpHit`  out  1  registered, sticky while in BREAK
- `o_bpHitIdx`  out  $clog2(NUM_BP) (min 1)  index of the lowest matching entry

## Operation
- Input conditioning:
  - All switches and the button pass through 2-flop synchronisers.
  - The button is then debounced: a counter reloads on any change of the synced level; the level is accepted after `DEBOUNCE_CYCLES` stable cycles.
  - A rising edge of the accepted level produces a one-cycle `stepReq`.
- States:
  - HALT: enable 0.
    - Run mode (synced swStepNRun=0) -> RUN.
    - `stepReq` in cycle mode -> one `o_cpuClkEn` pulse, stay in HALT.
    - `stepReq` in instruction mode -> STEP_INSTR.
  - STEP_INSTR: enable 1 every cycle.
    - A cycle with enable=1 and `i_instrBoundary`=1 is the last one; next state is HALT.
    - `stepReq` and switch changes are ignored until then.
  - RUN: enable 1 every cycle.
    - Breakpoint match on an enabled boundary cycle: that boundary cycle still completes, then -> BREAK with `o_bpHit`=1 and `o_bpHitIdx` latched.
    - Otherwise, synced swStepNRun=1 -> STEP_INSTR, so the current instruction finishes.
  - BREAK: enable 0.
    - `stepReq` clears `o_bpHit`, then behaves as the HALT `stepReq` rule in step mode, or -> RUN in run mode.
- Breakpoint match condition: swEnableBreakpoint synced=1 AND `i_bpValid[k]` AND `i_pc`==entry k. The lowest k wins.
- Breakpoints are evaluated in RUN only, never in STEP_INSTR or cycle steps.
- Toggling swEnableBreakpoint while in BREAK does not leave BREAK.
- Reset values: `o_cpuClkEn`=0, `o_halted`=1, `o_bpHit`=0, `o_bpHitIdx`=0, state HALT, accepted button level 0, debounce counter cleared.

## Timing
- Button rise held stable: `stepReq` occurs `DEBOUNCE_CYCLES`+2 edges after the first sampling edge. The first `o_cpuClkEn` high cycle follows 1 cycle later.
- Switch changes act 3 cycles after the first sampling edge (2 sync + 1 registered output).
- Breakpoint: BREAK is entered and `o_cpuClkEn`=0 on the cycle after the matching boundary cycle; no extra microcycle executes.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no `stepReq`; release also requires a stable level before the next press counts.
- Async reset mid-operation: all outputs take their reset values immediately, without waiting for a clock edge. The first `stepReq` after deassertion requires a full debounce interval.

## Configuration
- `DEBUG_BREAKPOINT_EN` defined: comparators, BREAK state and hit outputs are implemented.
- Undefined:
  - Comparators and the BREAK state are not generated.
  - `o_bpHit` and `o_bpHitIdx` are tied to 0.
  - `i_bpAddress`, `i_bpValid` and `i_swEnableBreakpoint` remain as ports and are ignored.
  - RUN exits only via swStepNRun.

## Structure
- Package `edic_debug_pkg` holds:
  - state enum `dbg_state_t` (HALT, STEP_INSTR, RUN, BREAK);
  - `DBG_SYNC_STAGES`=2.
- Sub-module `button_debouncer`, parameterised by `DEBOUNCE_CYCLES`: synchroniser, counter and rising-edge pulse.
- Top level contains the FSM and the breakpoint comparator/priority encoder.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `NUM_BP`=4, `ADDR_WIDTH`=16.
- Hold `i_nReset`=0, toggle every input -> `o_cpuClkEn`=0, `o_halted`=1, `o_bpHit`=0 throughout.
- Step mode, cycle mode, button held high 10 cycles -> exactly one `o_cpuClkEn` pulse, 7 edges after the first sampling edge; `o_halted` stays 1.
- Instruction mode, boundary model asserting `i_instrBoundary` every 3rd enabled cycle, one press -> exactly 3 enable cycles, then HALT.
- Button toggled every 2 cycles for 20 cycles, then held 0 -> no `o_cpuClkEn` pulses.
- Run mode, breakpoints enabled, entry 2 = 0x0028 valid, `i_pc` increments by 1 per boundary:
  - boundary with `i_pc`=0x0028 -> next cycle `o_cpuClkEn`=0, `o_halted`=1, `o_bpHit`=1, `o_bpHitIdx`=2;
  - then a press -> `o_bpHit`=0 and free run resumes.
- Pull `i_nReset` low during STEP_INSTR -> outputs at reset values before the next clock edge; after release, a press is needed to move again.
